// File: rtl/ex_operand_stage_if.sv
// Bus bundle for the ID/EX operand stage: decoded ID operands, MEM/WB forwarding
// buses and the EX-side operand outputs.
interface ex_operand_stage_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned REG_AW = 5
) ();
  logic              stall;
  logic              flush;
  logic              id_valid;
  logic [WIDTH-1:0]  id_rs_val;
  logic [WIDTH-1:0]  id_rt_val;
  logic [WIDTH-1:0]  id_imm;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_alu_src;
  logic              mem_we;
  logic [REG_AW-1:0] mem_rd;
  logic [WIDTH-1:0]  mem_val;
  logic              wb_we;
  logic [REG_AW-1:0] wb_rd;
  logic [WIDTH-1:0]  wb_val;
  logic              ex_valid;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;
  logic [WIDTH-1:0]  store_data;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;

  modport master (
    output stall, flush, id_valid, id_rs_val, id_rt_val, id_imm, id_rs, id_rt, id_alu_src,
    output mem_we, mem_rd, mem_val, wb_we, wb_rd, wb_val,
    input  ex_valid, op_a, op_b, store_data, fwd_a, fwd_b
  );

  modport slave (
    input  stall, flush, id_valid, id_rs_val, id_rt_val, id_imm, id_rs, id_rt, id_alu_src,
    input  mem_we, mem_rd, mem_val, wb_we, wb_rd, wb_val,
    output ex_valid, op_a, op_b, store_data, fwd_a, fwd_b
  );
endinterface

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with stall/flush, plus same-cycle MEM/WB operand forwarding
// and ALU operand-B select.
module ex_operand_stage #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned REG_AW = 5
) (
  input logic              clk,
  input logic              reset,
  ex_operand_stage_if.slave bus
);

  logic              valid_q,   valid_d;
  logic [WIDTH-1:0]  rs_val_q,  rs_val_d;
  logic [WIDTH-1:0]  rt_val_q,  rt_val_d;
  logic [WIDTH-1:0]  imm_q,     imm_d;
  logic [REG_AW-1:0] rs_q,      rs_d;
  logic [REG_AW-1:0] rt_q,      rt_d;
  logic              alu_src_q, alu_src_d;

  // Flush beats stall; a bubble clears rs/rt so it can never match a forward.
  always_comb begin
    valid_d   = valid_q;
    rs_val_d  = rs_val_q;
    rt_val_d  = rt_val_q;
    imm_d     = imm_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    alu_src_d = alu_src_q;
    if (bus.flush) begin
      valid_d   = 1'b0;
      rs_val_d  = '0;
      rt_val_d  = '0;
      imm_d     = '0;
      rs_d      = '0;
      rt_d      = '0;
      alu_src_d = 1'b0;
    end else if (!bus.stall) begin
      valid_d   = bus.id_valid;
      rs_val_d  = bus.id_rs_val;
      rt_val_d  = bus.id_rt_val;
      imm_d     = bus.id_imm;
      rs_d      = bus.id_rs;
      rt_d      = bus.id_rt;
      alu_src_d = bus.id_alu_src;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q   <= 1'b0;
      rs_val_q  <= '0;
      rt_val_q  <= '0;
      imm_q     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      alu_src_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      rs_val_q  <= rs_val_d;
      rt_val_q  <= rt_val_d;
      imm_q     <= imm_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      alu_src_q <= alu_src_d;
    end
  end

  logic mem_hit_a, wb_hit_a, mem_hit_b, wb_hit_b;
  logic [WIDTH-1:0] rs_fwd, rt_fwd;

  assign mem_hit_a = bus.mem_we && (bus.mem_rd == rs_q) && (rs_q != '0);
  assign wb_hit_a  = bus.wb_we  && (bus.wb_rd  == rs_q) && (rs_q != '0);
  assign mem_hit_b = bus.mem_we && (bus.mem_rd == rt_q) && (rt_q != '0);
  assign wb_hit_b  = bus.wb_we  && (bus.wb_rd  == rt_q) && (rt_q != '0);

  // MEM holds the younger write, so it wins over WB.
  always_comb begin
    bus.fwd_a = 2'b00;
    rs_fwd    = rs_val_q;
    if (mem_hit_a) begin
      bus.fwd_a = 2'b10;
      rs_fwd    = bus.mem_val;
    end else if (wb_hit_a) begin
      bus.fwd_a = 2'b01;
      rs_fwd    = bus.wb_val;
    end
  end

  always_comb begin
    bus.fwd_b = 2'b00;
    rt_fwd    = rt_val_q;
    if (mem_hit_b) begin
      bus.fwd_b = 2'b10;
      rt_fwd    = bus.mem_val;
    end else if (wb_hit_b) begin
      bus.fwd_b = 2'b01;
      rt_fwd    = bus.wb_val;
    end
  end

  assign bus.ex_valid   = valid_q;
  assign bus.op_a       = rs_fwd;
  assign bus.store_data = rt_fwd;
  assign bus.op_b       = alu_src_q ? imm_q : rt_fwd;

endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

Parametrised ID/EX operand stage for the pipelined MIPS datapath. Each cycle it latches decoded operands (rs/rt values, sign-extended immediate, register numbers, ALU-source select) into the ID/EX pipeline register, with stall-hold and flush-to-bubble control. In the EX cycle it resolves RAW hazards by forwarding from the MEM and WB stages and selects ALU operand B (forwarded rt or immediate). It replaces the plain rt/immediate operand-B select in front of the ALU.

## Interface
Parameters:
- WIDTH, 32, data width of operands and forwarding buses
- REG_AW, 5, register-number width

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high
- stall  in  1  hold ID/EX register contents
- flush  in  1  load a bubble into ID/EX register
- id_valid  in  1  ID stage holds a real instruction
- id_rs_val  in  WIDTH  register-file value of rs
- id_rt_val  in  WIDTH  register-file value of rt
- id_imm  in  WIDTH  sign-extended immediate
- id_rs  in  REG_AW  rs number
- id_rt  in  REG_AW  rt number
- id_alu_src  in  1  1 = operand B from immediate, 0 = from rt
- mem_we  in  1  MEM-stage instruction writes a register
- mem_rd  in  REG_AW  MEM-stage destination
- mem_val  in  WIDTH  MEM-stage result
- wb_we  in  1  WB-stage instruction writes a register
- wb_rd  in  REG_AW  WB-stage destination
- wb_val  in  WIDTH  WB-stage result
- ex_valid  out  1  EX stage holds a real instruction
- op_a  out  WIDTH  ALU operand A (forwarded rs)
- op_b  out  WIDTH  ALU operand B
- store_data  out  WIDTH  forwarded rt, for stores
- fwd_a  out  2  source of op_a: 00 regfile, 01 WB, 10 MEM
- fwd_b  out  2  source of forwarded rt, same encoding

## Operation
- ID/EX register fields: valid, rs_val, rt_val, imm, rs, rt, alu_src.
- Register update at clk rising edge, priority: reset > flush > stall > load.
  - reset (async): all fields 0.
  - flush: valid=0, rs=rt=0, alu_src=0; data fields 0. Flush overrides a simultaneous stall.
  - stall: all fields hold.
  - otherwise: load from id_* inputs (valid from id_valid).
- Forwarding, combinational from latched rs/rt and current MEM/WB buses:
  - MEM hit: mem_we && mem_rd == rs && rs != 0 -> fwd_a=10, value mem_val.
  - else WB hit: wb_we && wb_rd == rs && rs != 0 -> fwd_a=01, value wb_val.
  - else fwd_a=00, value latched rs_val.
  - Same rules for rt -> fwd_b, forwarded rt value.
  - MEM has priority over WB when both match (most recent write).
  - Register 0 is never forwarded; op uses latched value.
  - Forwarding is evaluated even when valid=0; consumers qualify with ex_valid. A bubble has rs=rt=0, so fwd_a=fwd_b=00.
- op_a = forwarded rs. store_data = forwarded rt. op_b = alu_src ? imm : forwarded rt (the forwarding path never overrides the immediate).
- ex_valid = latched valid.
- No arithmetic; all data paths pass WIDTH bits unmodified.

## Timing
- Latency: id_* captured at edge N appear on outputs during cycle N+1.
- Forwarding path is same-cycle: a change on mem_*/wb_* changes op_a/op_b/store_data/fwd_* in that cycle, with no register.
- While reset is asserted: ex_valid=0, op_a=op_b=store_data=0, fwd_a=fwd_b=00, regardless of mem_*/wb_*, because latched rs=rt=0.
- Reset mid-stall: reset wins immediately (async); stall has no effect until reset deasserts.
- Stall for K cycles: outputs reflect the same latched instruction for K+1 cycles. Forwarded values may change across those cycles as MEM/WB advance.
- First edge after reset deassertion performs a normal load (or flush/stall per inputs).

## Test plan
- Reset: assert reset mid-run with mem_we=1, mem_rd=0 -> ex_valid=0, op_a=op_b=store_data=0, fwd_a=fwd_b=00 immediately. After release, load rs=1 (val 0x11), rt=2 (val 0x22), alu_src=0 -> next cycle op_a=0x11, op_b=0x22.
- Immediate select: rt=2 (val 0x22), imm=0xFFFFFFFC, alu_src=1, no hazards -> op_b=0xFFFFFFFC, store_data=0x22, fwd_b=00.
- Priority: latched rs=rt=3; mem_we=1, mem_rd=3, mem_val=0xAAAA; wb_we=1, wb_rd=3, wb_val=0xBBBB -> op_a=op_b=0xAAAA, fwd_a=fwd_b=10. Drop mem_we -> op_a=0xBBBB, fwd_a=01 in the same cycle.
- Register 0: latched rs=0 (val 0), mem_we=1, mem_rd=0, mem_val=0x1234 -> op_a=0, fwd_a=00.
- Stall/flush: stall=1 for 3 cycles while id_* change -> outputs hold the original instruction 4 cycles. Then assert stall=1 and flush=1 together -> next cycle ex_valid=0, fwd_a=fwd_b=00.
- Forwarding during stall: stall holds rs=5; at cycle 1 mem_rd=5 gives op_a=mem_val, fwd 10; at cycle 2 only wb_rd=5 gives op_a=wb_val, fwd 01.
